// File: rtl/store_drain_unit_pkg.sv
// Shared types for the store drain path: store uop bundle,
// drain FSM states and the MMIO address classifier.
package store_drain_unit_pkg;

  localparam int SDU_DEPTH = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic        isMMIO;
  } ST_UOp;

  typedef enum logic {
    SDU_IDLE,
    SDU_MMIO_REQ
  } SDU_State;

  // Word addresses in the top 256 MiB belong to the MMIO region.
  function automatic logic is_mmio_pma_w(input logic [29:0] w);
    return w[29:26] == 4'hF;
  endfunction

endpackage

// File: rtl/store_drain_unit_if.sv
// Store queue handshake and MMIO write bus seen by the drain unit.
// slave = drain unit side, master = store queue / MMIO target side.
interface store_drain_unit_if;
  import store_drain_unit_pkg::*;

  ST_UOp       IN_uopSt;
  logic        OUT_stall;
  logic        OUT_mmioReq;
  logic [31:0] OUT_mmioAddr;
  logic [31:0] OUT_mmioData;
  logic [3:0]  OUT_mmioMask;
  logic        IN_mmioAck;

  modport slave (
    input  IN_uopSt, IN_mmioAck,
    output OUT_stall, OUT_mmioReq,
    output OUT_mmioAddr, OUT_mmioData,
    output OUT_mmioMask
  );

  modport master (
    output IN_uopSt, IN_mmioAck,
    input  OUT_stall, OUT_mmioReq,
    input  OUT_mmioAddr, OUT_mmioData,
    input  OUT_mmioMask
  );

endinterface

// File: rtl/store_drain_unit_fifo.sv
// In-order circular store buffer; exposes every slot and its
// valid bit so the drain unit can forward buffered bytes.
module store_buf_fifo
  import store_drain_unit_pkg::*;
#(
  parameter int DEPTH = SDU_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  ST_UOp         i_data,
  input  logic          i_pop,
  output ST_UOp         o_head,
  output logic [PW-1:0] o_headPtr,
  output logic          o_full,
  output logic          o_empty,
  output ST_UOp         o_ent [DEPTH],
  output logic          o_vld [DEPTH]
);

  ST_UOp         r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  logic [PW-1:0] w_off [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i] = PW'(i) - r_head;
      o_vld[i] = {1'b0, w_off[i]} < r_count;
      o_ent[i] = r_mem[i];
    end
  end

  assign o_head    = r_mem[r_head];
  assign o_headPtr = r_head;
  assign o_full    = r_count == (PW+1)'(DEPTH);
  assign o_empty   = r_count == '0;

endmodule

// File: rtl/store_drain_unit.sv
// Drains committed stores in order to the D-cache write port or
// the MMIO bus; forwards buffered bytes to loads, reports idle.
module store_drain_unit
  import store_drain_unit_pkg::*;
#(
  parameter int DEPTH = SDU_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  store_drain_unit_if.slave   sif,
  input  logic                IN_dcBusy,
  output ST_UOp               OUT_dcWr,
  output logic                OUT_fence,
  input  logic                IN_ldValid,
  input  logic [31:0]         IN_ldAddr,
  output logic [31:0]         OUT_fwdData,
  output logic [3:0]          OUT_fwdMask,
  output logic                OUT_idle
);

  SDU_State      r_state, w_nxt;
  ST_UOp         r_dcWr;
  logic          r_fence;
  logic          r_mmioReq;
  logic [31:0]   r_mmioAddr;
  logic [31:0]   r_mmioData;
  logic [3:0]    r_mmioMask;

  ST_UOp         w_head;
  ST_UOp         w_ent [DEPTH];
  logic          w_vld [DEPTH];
  logic [PW-1:0] w_headPtr;
  logic          w_full, w_empty, w_acc, w_pop;
  logic          w_isFence, w_isMmio;
  logic          w_wrV, w_fenceN, w_mmioGo, w_mmioDone;

  assign w_acc = sif.IN_uopSt.valid && !w_full;

  store_buf_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_acc),
    .i_data    (sif.IN_uopSt),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_headPtr (w_headPtr),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_ent     (w_ent),
    .o_vld     (w_vld)
  );

  assign w_isFence = w_head.wmask == 4'b0;
  assign w_isMmio  = !w_isFence && is_mmio_pma_w(w_head.addr[31:2]);

  always_comb begin
    w_nxt      = r_state;
    w_pop      = 1'b0;
    w_wrV      = 1'b0;
    w_fenceN   = 1'b0;
    w_mmioGo   = 1'b0;
    w_mmioDone = 1'b0;
    unique case (r_state)
      SDU_IDLE: if (!w_empty) begin
        unique case (1'b1)
          w_isFence: if (!r_dcWr.valid) begin
            w_pop    = 1'b1;
            w_fenceN = 1'b1;
          end
          w_isMmio: begin
            w_mmioGo = 1'b1;
            w_nxt    = SDU_MMIO_REQ;
          end
          default: if (!IN_dcBusy) begin
            w_pop = 1'b1;
            w_wrV = 1'b1;
          end
        endcase
      end
      SDU_MMIO_REQ: if (sif.IN_mmioAck) begin
        w_pop      = 1'b1;
        w_mmioDone = 1'b1;
        w_nxt      = SDU_IDLE;
      end
      default: w_nxt = SDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SDU_IDLE;
      r_dcWr     <= '0;
      r_fence    <= 1'b0;
      r_mmioReq  <= 1'b0;
      r_mmioAddr <= '0;
      r_mmioData <= '0;
      r_mmioMask <= '0;
    end else begin
      r_state      <= w_nxt;
      r_fence      <= w_fenceN;
      r_dcWr.valid <= w_wrV;
      if (w_wrV) begin
        r_dcWr.addr   <= w_head.addr;
        r_dcWr.data   <= w_head.data;
        r_dcWr.wmask  <= w_head.wmask;
        r_dcWr.isMMIO <= 1'b0;
      end
      if (w_mmioGo) begin
        r_mmioReq  <= 1'b1;
        r_mmioAddr <= {w_head.addr[31:2], 2'b00};
        r_mmioData <= w_head.data;
        r_mmioMask <= w_head.wmask;
      end else if (w_mmioDone) begin
        r_mmioReq  <= 1'b0;
      end
    end
  end

  // Merge oldest (in-flight cache write) to youngest buffer slot.
  always_comb begin
    OUT_fwdData = 'x;
    OUT_fwdMask = 4'b0;
    if (IN_ldValid) begin
      if (r_dcWr.valid && r_dcWr.addr[31:2] == IN_ldAddr[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (r_dcWr.wmask[b]) OUT_fwdData[8*b +: 8] = r_dcWr.data[8*b +: 8];
        end
        OUT_fwdMask = r_dcWr.wmask;
      end
      for (int i = 0; i < DEPTH; i++) begin
        automatic logic [PW-1:0] idx = w_headPtr + PW'(i);
        automatic ST_UOp e = w_ent[idx];
        if (w_vld[idx] && e.wmask != 4'b0 &&
            !is_mmio_pma_w(e.addr[31:2]) &&
            e.addr[31:2] == IN_ldAddr[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (e.wmask[b]) OUT_fwdData[8*b +: 8] = e.data[8*b +: 8];
          end
          OUT_fwdMask = OUT_fwdMask | e.wmask;
        end
      end
    end
  end

  assign sif.OUT_stall    = w_full;
  assign sif.OUT_mmioReq  = r_mmioReq;
  assign sif.OUT_mmioAddr = r_mmioAddr;
  assign sif.OUT_mmioData = r_mmioData;
  assign sif.OUT_mmioMask = r_mmioMask;
  assign OUT_dcWr  = r_dcWr;
  assign OUT_fence = r_fence;
  assign OUT_idle  = w_empty && r_state == SDU_IDLE &&
                     !r_dcWr.valid && !r_mmioReq;

endmodule
